cc_unit: RTL and testbench

CC_UNIT -- requirements
Module: cc_unit

---
 rtl/cc_unit_pkg.sv | 16 +
 rtl/cc_unit_cond_eval.sv | 21 ++
 rtl/cc_unit.sv | 38 +++
 tb/tb_cc_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cc_unit_pkg.sv
// cc_unit_pkg: condition-code encodings, flag bit positions and reset value shared by the pipeline
package cc_unit_pkg;
   typedef enum logic [3:0] {
      C_ALWAYS = 4'd0,
      C_LE     = 4'd1,
      C_L      = 4'd2,
      C_E      = 4'd3,
      C_NE     = 4'd4,
      C_GE     = 4'd5,
      C_G      = 4'd6
   } cond_e;
   localparam int CC_OF = 2;
   localparam int CC_SF = 1;
   localparam int CC_ZF = 0;
   localparam logic [2:0] CC_RST = 3'b001;
endpackage

// File: rtl/cc_unit_cond_eval.sv
// cond_eval: combinational jXX/cmovXX condition from a CC value and ifun
module cond_eval
   import cc_unit_pkg::*;
(
   input  logic [2:0] cc,
   input  logic [3:0] ifun,
   output logic       cnd
);
   logic lt, eq;
   assign lt = cc[CC_SF] ^ cc[CC_OF];
   assign eq = cc[CC_ZF];
   always_comb begin
      cnd = ifun == C_ALWAYS ? 1'b1 :
            ifun == C_LE     ? lt | eq :
            ifun == C_L      ? lt :
            ifun == C_E      ? eq :
            ifun == C_NE     ? ~eq :
            ifun == C_GE     ? ~lt :
            ifun == C_G      ? ~lt & ~eq : 1'b0;
   end
endmodule

// File: rtl/cc_unit.sv
// cc_unit: condition-code register, E-stage condition evaluation and saturating taken counter
module cc_unit
   import cc_unit_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_cc,
   input  logic [2:0]       cf_in,
   input  logic             e_valid,
   input  logic             e_stall,
   input  logic             exc_m,
   input  logic             exc_w,
   input  logic [3:0]       ifun,
   input  logic             use_cnd,
   input  logic             cnt_clr,
   output logic             e_cnd,
   output logic [2:0]       cc_q,
   output logic [CNT_W-1:0] taken_cnt
);
   logic cnd, update, inc;
   cond_eval u_cond (.cc(cc_q), .ifun(ifun), .cnd(cnd));
   assign e_cnd  = e_valid & cnd;
   assign update = set_cc & e_valid & ~e_stall & ~exc_m & ~exc_w;
   assign inc    = use_cnd & e_valid & ~e_stall & e_cnd;
   // the counter sticks at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_q      <= CC_RST;
         taken_cnt <= '0;
      end else begin
         if (update) cc_q <= cf_in;
         if (cnt_clr) taken_cnt <= '0;
         else if (inc && !(&taken_cnt)) taken_cnt <= taken_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_cc_unit.sv
// tb_cc_unit: randomized scoreboard bench for cc_unit against an arithmetic-level flag/condition model
module tb_cc_unit;
   localparam int W = 4;
   logic clk = 0, rst_n = 0;
   logic set_cc = 0, e_valid = 0, e_stall = 0, exc_m = 0, exc_w = 0, use_cnd = 0, cnt_clr = 0;
   logic [2:0] cf_in = 0;
   logic [3:0] ifun = 0;
   logic e_cnd;
   logic [2:0] cc_q;
   logic [W-1:0] taken_cnt;

   cc_unit #(.CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .set_cc(set_cc), .cf_in(cf_in), .e_valid(e_valid),
      .e_stall(e_stall), .exc_m(exc_m), .exc_w(exc_w), .ifun(ifun), .use_cnd(use_cnd),
      .cnt_clr(cnt_clr), .e_cnd(e_cnd), .cc_q(cc_q), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] cc;
      logic       cnd;
      int         cnt;
   } exp_t;
   exp_t q[$];
   int checks = 0, passed = 0;
   logic [2:0] m_cc = 3'b001;
   int m_cnt = 0;

   // flags of a 64-bit signed add, derived from the arithmetic result
   function automatic logic [2:0] add_flags(input logic [63:0] a, input logic [63:0] b);
      logic signed [64:0] wide;
      logic [63:0] s;
      wide = {a[63], a} + {b[63], b};
      s = a + b;
      return {wide[64] != wide[63], s[63], s == 64'd0};
   endfunction

   function automatic logic cond_ref(input logic [2:0] cc, input int f);
      bit less, equal;
      less = cc[1] != cc[2];
      equal = cc[0];
      case (f)
         0: return 1'b1;
         1: return less || equal;
         2: return less;
         3: return equal;
         4: return !equal;
         5: return !less;
         6: return !less && !equal;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("cc_q", int'(cc_q), int'(e.cc));
         chk("e_cnd", int'(e_cnd), int'(e.cnd));
         chk("taken_cnt", int'(taken_cnt), e.cnt);
      end
   end

   task automatic step(input bit set, input logic [63:0] a, input logic [63:0] b, input bit v,
                       input bit st, input bit em, input bit ew, input int f, input bit u, input bit c);
      logic [2:0] cf;
      logic cnd;
      @(posedge clk);
      #1;
      cf = add_flags(a, b);
      set_cc = set; cf_in = cf; e_valid = v; e_stall = st; exc_m = em; exc_w = ew;
      ifun = 4'(f); use_cnd = u; cnt_clr = c;
      cnd = v && cond_ref(m_cc, f);
      q.push_back('{m_cc, cnd, m_cnt});
      if (c) m_cnt = 0;
      else if (u && v && !st && cnd && m_cnt < (1 << W) - 1) m_cnt++;
      if (set && v && !st && !em && !ew) m_cc = cf;
   endtask

   // reset asserted mid-cycle while an update and an increment are requested
   task automatic reset_mid();
      @(posedge clk);
      #1;
      set_cc = 1; cf_in = 3'b110; e_valid = 1; e_stall = 0; exc_m = 0; exc_w = 0;
      ifun = 4'd3; use_cnd = 1; cnt_clr = 0;
      #2;
      rst_n = 0;
      m_cc = 3'b001;
      m_cnt = 0;
      q.push_back('{3'b001, 1'b1, 0});
      @(posedge clk);
      #1;
      q.push_back('{3'b001, 1'b1, 0});
      #2;
      rst_n = 1;
      if (cond_ref(m_cc, 0) && m_cnt < (1 << W) - 1) m_cnt++;
      m_cc = 3'b110;
   endtask

   localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

   initial begin
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      step(1, MAXP, 64'd1, 1, 0, 0, 0, 2, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 2, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 5, 0, 0);
      step(1, -64'sd11, 64'd4, 1, 0, 1, 0, 1, 0, 0);
      step(1, -64'sd11, 64'd4, 1, 1, 0, 0, 1, 0, 0);
      step(1, -64'sd11, 64'd4, 1, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 2, 0, 0);
      step(1, 64'd11, -64'sd11, 1, 0, 0, 0, 3, 0, 0);
      step(1, 64'd11, 64'd4, 1, 0, 0, 0, 3, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 3, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
      reset_mid();
      step(0, 0, 0, 1, 0, 0, 0, 3, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 2, 1, 0);
      for (int i = 0; i < 400; i++) begin
         logic [63:0] a, b;
         a = {$urandom, $urandom};
         b = ($urandom_range(0, 4) == 0) ? -a : {$urandom, $urandom};
         if ($urandom_range(0, 5) == 0) a = MAXP;
         step($urandom_range(0, 1), a, b, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9),
              $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
